// File: rtl/kftvga_vram_arbiter.sv
// Text VRAM port arbiter: video fetch has absolute priority and a fixed two-edge return latency;
// host reads/writes use free slots. Define KFTVGA_VRAM_POSTED_WRITE_EN for a 1-entry posted write buffer.
module kftvga_vram_arbiter (
    input  logic        video_clock,
    input  logic        reset,
    input  logic        video_request,
    input  logic [12:0] video_address,
    output logic [15:0] video_data,
    output logic        video_data_valid,
    input  logic        host_request,
    input  logic        host_write,
    input  logic [12:0] host_address,
    input  logic [15:0] host_write_data,
    output logic        host_acknowledge,
    output logic [15:0] host_read_data,
    output logic [12:0] ram_address,
    output logic        ram_write_enable,
    output logic [15:0] ram_write_data,
    input  logic [15:0] ram_read_data
);
    localparam int RETURN_DEPTH = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PENDING,
        ST_READ_WAIT,
        ST_ACK,
        ST_HOLD
    } host_state_t;

    typedef enum logic [1:0] {
        OWNER_NONE,
        OWNER_VIDEO,
        OWNER_HOST
    } owner_t;

    host_state_t state_reg, state_next;
    owner_t      tag_reg [RETURN_DEPTH];
    owner_t      issue_owner;

    logic        host_slot_free;
    logic        host_issue;
    logic        drain_issue;
    logic        buffer_load;
    logic [12:0] drain_address;
    logic [15:0] drain_data;

    logic [12:0] ram_address_reg;
    logic        ram_write_enable_reg;
    logic [15:0] ram_write_data_reg;
    logic [15:0] video_data_reg;
    logic        video_data_valid_reg;
    logic [15:0] host_read_data_reg;
    logic        host_acknowledge_reg;

`ifdef KFTVGA_VRAM_POSTED_WRITE_EN
    logic        buffer_valid_reg;
    logic [12:0] buffer_address_reg;
    logic [15:0] buffer_data_reg;

    assign drain_address = buffer_address_reg;
    assign drain_data    = buffer_data_reg;
`else
    assign drain_address = '0;
    assign drain_data    = '0;
`endif

    // Host FSM and slot decision; a request seen in IDLE may issue in that same slot.
    always_comb begin
        state_next     = state_reg;
        host_issue     = 1'b0;
        drain_issue    = 1'b0;
        buffer_load    = 1'b0;
        host_slot_free = !video_request;
`ifdef KFTVGA_VRAM_POSTED_WRITE_EN
        drain_issue    = buffer_valid_reg && !video_request;
        host_slot_free = !video_request && !buffer_valid_reg;
`endif
        case (state_reg)
            ST_IDLE: begin
                if (host_request) begin
`ifdef KFTVGA_VRAM_POSTED_WRITE_EN
                    // A full buffer blocks acceptance, which also keeps reads behind the buffered write.
                    if (!buffer_valid_reg) begin
                        if (host_slot_free) begin
                            host_issue = 1'b1;
                            state_next = host_write ? ST_ACK : ST_READ_WAIT;
                        end else if (host_write) begin
                            buffer_load = 1'b1;
                            state_next  = ST_ACK;
                        end else begin
                            state_next = ST_PENDING;
                        end
                    end
`else
                    if (host_slot_free) begin
                        host_issue = 1'b1;
                        state_next = host_write ? ST_ACK : ST_READ_WAIT;
                    end else begin
                        state_next = ST_PENDING;
                    end
`endif
                end
            end
            ST_PENDING: begin
                if (!host_request) begin
                    state_next = ST_IDLE;
                end else if (host_slot_free) begin
                    host_issue = 1'b1;
                    state_next = host_write ? ST_ACK : ST_READ_WAIT;
                end
            end
            ST_READ_WAIT: begin
                if (tag_reg[RETURN_DEPTH-1] == OWNER_HOST) begin
                    state_next = ST_ACK;
                end
            end
            ST_ACK:  state_next = ST_HOLD;
            ST_HOLD: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        issue_owner = OWNER_NONE;
        if (video_request) begin
            issue_owner = OWNER_VIDEO;
        end else if (host_issue && !host_write) begin
            issue_owner = OWNER_HOST;
        end
    end

    always_ff @(negedge video_clock or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Single port slot: video, then buffered write, then direct host access.
    always_ff @(negedge video_clock or posedge reset) begin
        if (reset) begin
            ram_address_reg      <= '0;
            ram_write_enable_reg <= 1'b0;
            ram_write_data_reg   <= '0;
        end else if (video_request) begin
            ram_address_reg      <= video_address;
            ram_write_enable_reg <= 1'b0;
        end else if (drain_issue) begin
            ram_address_reg      <= drain_address;
            ram_write_data_reg   <= drain_data;
            ram_write_enable_reg <= 1'b1;
        end else if (host_issue) begin
            ram_address_reg      <= host_address;
            ram_write_enable_reg <= host_write;
            if (host_write) begin
                ram_write_data_reg <= host_write_data;
            end
        end else begin
            ram_write_enable_reg <= 1'b0;
        end
    end

    always_ff @(negedge video_clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < RETURN_DEPTH; i++) begin
                tag_reg[i] <= OWNER_NONE;
            end
        end else begin
            tag_reg[0] <= issue_owner;
            for (int i = 1; i < RETURN_DEPTH; i++) begin
                tag_reg[i] <= tag_reg[i-1];
            end
        end
    end

    always_ff @(negedge video_clock or posedge reset) begin
        if (reset) begin
            video_data_reg       <= '0;
            video_data_valid_reg <= 1'b0;
            host_read_data_reg   <= '0;
            host_acknowledge_reg <= 1'b0;
        end else begin
            video_data_valid_reg <= (tag_reg[RETURN_DEPTH-1] == OWNER_VIDEO);
            if (tag_reg[RETURN_DEPTH-1] == OWNER_VIDEO) begin
                video_data_reg <= ram_read_data;
            end
            if (tag_reg[RETURN_DEPTH-1] == OWNER_HOST) begin
                host_read_data_reg <= ram_read_data;
            end
            host_acknowledge_reg <= (state_reg == ST_ACK);
        end
    end

`ifdef KFTVGA_VRAM_POSTED_WRITE_EN
    always_ff @(negedge video_clock or posedge reset) begin
        if (reset) begin
            buffer_valid_reg   <= 1'b0;
            buffer_address_reg <= '0;
            buffer_data_reg    <= '0;
        end else if (buffer_load) begin
            buffer_valid_reg   <= 1'b1;
            buffer_address_reg <= host_address;
            buffer_data_reg    <= host_write_data;
        end else if (drain_issue) begin
            buffer_valid_reg <= 1'b0;
        end
    end
`endif

    assign ram_address      = ram_address_reg;
    assign ram_write_enable = ram_write_enable_reg;
    assign ram_write_data   = ram_write_data_reg;
    assign video_data       = video_data_reg;
    assign video_data_valid = video_data_valid_reg;
    assign host_read_data   = host_read_data_reg;
    assign host_acknowledge = host_acknowledge_reg;

endmodule

// File: tb/tb_kftvga_vram_arbiter.sv
// Bench for kftvga_vram_arbiter: table of host transactions plus reset, contention and streaming
// sequences; expected video/host completions are queued at drive time and popped on DUT output.
module tb_kftvga_vram_arbiter;
    logic        video_clock = 1'b0;
    logic        reset = 1'b1;
    logic        video_request = 1'b0;
    logic [12:0] video_address = '0;
    logic [15:0] video_data;
    logic        video_data_valid;
    logic        host_request = 1'b0;
    logic        host_write = 1'b0;
    logic [12:0] host_address = '0;
    logic [15:0] host_write_data = '0;
    logic        host_acknowledge;
    logic [15:0] host_read_data;
    logic [12:0] ram_address;
    logic        ram_write_enable;
    logic [15:0] ram_write_data;
    logic [15:0] ram_read_data = '0;

`ifdef KFTVGA_VRAM_POSTED_WRITE_EN
    localparam int WR_COLLIDE_LAT = 1;
`else
    localparam int WR_COLLIDE_LAT = 2;
`endif
    localparam int NUM_VECS = 12;

    typedef struct {
        logic        is_read;
        logic [15:0] data;
        int          min_edge;
        int          max_edge;
    } exp_t;

    typedef struct {
        logic        wr;
        logic [12:0] addr;
        logic [15:0] wdata;
        logic        with_video;
        logic [12:0] vaddr;
        int          lat;
        logic [15:0] rdata;
    } vec_t;

    exp_t        vq[$];
    exp_t        hq[$];
    exp_t        mon_e;
    logic [15:0] vram [int];
    logic [15:0] shadow [int];
    vec_t        vecs [NUM_VECS];
    int          checks = 0;
    int          errors = 0;
    int          edge_count = 0;
    bit          video_done = 1'b0;

    kftvga_vram_arbiter dut (
        .video_clock      (video_clock),
        .reset            (reset),
        .video_request    (video_request),
        .video_address    (video_address),
        .video_data       (video_data),
        .video_data_valid (video_data_valid),
        .host_request     (host_request),
        .host_write       (host_write),
        .host_address     (host_address),
        .host_write_data  (host_write_data),
        .host_acknowledge (host_acknowledge),
        .host_read_data   (host_read_data),
        .ram_address      (ram_address),
        .ram_write_enable (ram_write_enable),
        .ram_write_data   (ram_write_data),
        .ram_read_data    (ram_read_data)
    );

    always #20 video_clock = ~video_clock;

    function automatic logic [15:0] init_word(input logic [12:0] a);
        return {3'b000, a} ^ 16'hC35A;
    endfunction

    function automatic logic [15:0] vram_rd(input logic [12:0] a);
        return vram.exists(int'(a)) ? vram[int'(a)] : init_word(a);
    endfunction

    function automatic logic [15:0] shadow_rd(input logic [12:0] a);
        return shadow.exists(int'(a)) ? shadow[int'(a)] : init_word(a);
    endfunction

    // Synchronous VRAM macro: read-first, data one falling edge after the address.
    always @(negedge video_clock) begin
        ram_read_data <= vram_rd(ram_address);
        if (ram_write_enable) vram[int'(ram_address)] = ram_write_data;
    end

    always @(negedge video_clock) edge_count <= edge_count + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic push_video(input logic [12:0] a, input int n);
        vq.push_back('{1'b0, shadow_rd(a), n + 2, n + 2});
    endtask

    task automatic host_wait_ack();
        bit got;
        got = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge video_clock);
            if (host_acknowledge) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL host_ack_timeout actual=none required=ack within 30 cycles");
        end
        host_request = 1'b0;
    endtask

    task automatic host_txn(input logic wr, input logic [12:0] a, input logic [15:0] d,
                            input int lmin, input int lmax);
        int n;
        @(posedge video_clock);
        n = edge_count + 1;
        host_request    = 1'b1;
        host_write      = wr;
        host_address    = a;
        host_write_data = d;
        if (wr) shadow[int'(a)] = d;
        hq.push_back('{!wr, shadow_rd(a), n + lmin, n + lmax});
        $display("host %s addr=0x%04h data=0x%04h edge=%0d", wr ? "wr" : "rd", a, d, n);
        host_wait_ack();
    endtask

    // Scoreboard: every completion the DUT signals must match the oldest queued expectation.
    always @(posedge video_clock) begin
        if (!reset) begin
            if (video_data_valid) begin
                if (vq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL video_unexpected actual=valid data=0x%04h required=no valid", video_data);
                end else begin
                    mon_e = vq.pop_front();
                    check_range("video_latency", edge_count, mon_e.min_edge, mon_e.max_edge);
                    check("video_data", 32'(video_data), 32'(mon_e.data));
                end
            end
            if (host_acknowledge) begin
                if (hq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL host_unexpected_ack actual=ack required=no ack");
                end else begin
                    mon_e = hq.pop_front();
                    check_range("host_ack_edge", edge_count, mon_e.min_edge, mon_e.max_edge);
                    if (mon_e.is_read) check("host_read_data", 32'(host_read_data), 32'(mon_e.data));
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_video_data"}, 32'(video_data), 32'h0);
        check({tag, "_video_valid"}, 32'(video_data_valid), 32'h0);
        check({tag, "_host_ack"}, 32'(host_acknowledge), 32'h0);
        check({tag, "_host_rdata"}, 32'(host_read_data), 32'h0);
        check({tag, "_ram_address"}, 32'(ram_address), 32'h0);
        check({tag, "_ram_we"}, 32'(ram_write_enable), 32'h0);
        check({tag, "_ram_wdata"}, 32'(ram_write_data), 32'h0);
    endtask

    initial begin
        int          n;
        int          wr_count;
        logic [15:0] last_rd;

        //           wr    addr      wdata     vid   vaddr     lat             rdata
        vecs[0]  = '{1'b1, 13'h0123, 16'h1F41, 1'b0, 13'h0000, 1,              16'h0000};
        vecs[1]  = '{1'b0, 13'h0123, 16'h0000, 1'b0, 13'h0000, 3,              16'h1F41};
        vecs[2]  = '{1'b0, 13'h0123, 16'h0000, 1'b1, 13'h0000, 4,              16'h1F41};
        vecs[3]  = '{1'b1, 13'h0200, 16'hAAAA, 1'b1, 13'h0010, WR_COLLIDE_LAT, 16'h0000};
        vecs[4]  = '{1'b0, 13'h0200, 16'h0000, 1'b0, 13'h0000, 3,              16'hAAAA};
        vecs[5]  = '{1'b1, 13'h1FFF, 16'hFFFF, 1'b1, 13'h1FFF, WR_COLLIDE_LAT, 16'h0000};
        vecs[6]  = '{1'b0, 13'h1FFF, 16'h0000, 1'b0, 13'h0000, 3,              16'hFFFF};
        vecs[7]  = '{1'b1, 13'h0000, 16'h0000, 1'b0, 13'h0000, 1,              16'h0000};
        vecs[8]  = '{1'b0, 13'h0000, 16'h0000, 1'b1, 13'h0001, 4,              16'h0000};
        vecs[9]  = '{1'b1, 13'h0123, 16'h1F41, 1'b0, 13'h0000, 1,              16'h0000};
        vecs[10] = '{1'b1, 13'h0123, 16'h1F41, 1'b0, 13'h0000, 1,              16'h0000};
        vecs[11] = '{1'b0, 13'h0123, 16'h0000, 1'b0, 13'h0000, 3,              16'h1F41};
        last_rd  = 16'h0000;

        repeat (2) @(posedge video_clock);
        check_all_zero("reset");
        reset = 1'b0;
        repeat (2) @(posedge video_clock);

        for (int i = 0; i < NUM_VECS; i++) begin
            @(posedge video_clock);
            n = edge_count + 1;
            host_request    = 1'b1;
            host_write      = vecs[i].wr;
            host_address    = vecs[i].addr;
            host_write_data = vecs[i].wdata;
            video_request   = vecs[i].with_video;
            video_address   = vecs[i].vaddr;
            if (vecs[i].with_video) push_video(vecs[i].vaddr, n);
            if (vecs[i].wr) shadow[int'(vecs[i].addr)] = vecs[i].wdata;
            hq.push_back('{!vecs[i].wr, vecs[i].rdata, n + vecs[i].lat, n + vecs[i].lat});
            $display("vec %0d %s addr=0x%04h wdata=0x%04h video=%0b lat=%0d",
                     i, vecs[i].wr ? "wr" : "rd", vecs[i].addr, vecs[i].wdata, vecs[i].with_video, vecs[i].lat);
            @(posedge video_clock);
            video_request = 1'b0;
            if (!vecs[i].with_video) begin
                check("ram_we", 32'(ram_write_enable), 32'(vecs[i].wr));
                check("ram_address", 32'(ram_address), 32'(vecs[i].addr));
                if (vecs[i].wr) check("ram_wdata", 32'(ram_write_data), 32'(vecs[i].wdata));
            end
            host_wait_ack();
            if (vecs[i].wr) check("host_rdata_hold", 32'(host_read_data), 32'(last_rd));
            else last_rd = vecs[i].rdata;
            repeat (2) @(posedge video_clock);
        end

        // Reset between issue and acknowledge discards the read.
        @(posedge video_clock);
        host_request = 1'b1;
        host_write   = 1'b0;
        host_address = 13'h0123;
        $display("reset mid-read addr=0x0123");
        repeat (2) @(posedge video_clock);
        reset = 1'b1;
        hq.delete();
        host_request = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge video_clock);
            check("rst_no_ack", 32'(host_acknowledge), 32'h0);
        end
        check_all_zero("midrst");
        reset = 1'b0;
        @(posedge video_clock);
        host_txn(1'b0, 13'h0123, 16'h0000, 3, 3);
        @(posedge video_clock);

        // Back-to-back video (protocol violation): video keeps latency 2, host waits 3 slots.
        @(posedge video_clock);
        n = edge_count + 1;
        host_request = 1'b1;
        host_write   = 1'b0;
        host_address = 13'h0123;
        hq.push_back('{1'b1, shadow_rd(13'h0123), n + 6, n + 6});
        $display("b2b video x3 with host rd addr=0x0123 edge=%0d", n);
        for (int k = 0; k < 3; k++) begin
            video_request = 1'b1;
            video_address = 13'h0100 + 13'(k);
            push_video(video_address, n + k);
            @(posedge video_clock);
        end
        video_request = 1'b0;
        host_wait_ack();
        repeat (2) @(posedge video_clock);

        // Video every second cycle while the host writes continuously.
        wr_count = 0;
        fork
            begin
                for (int k = 0; k < 80; k++) begin
                    @(posedge video_clock);
                    video_request = 1'b1;
                    video_address = 13'h0800 + 13'(k);
                    push_video(video_address, edge_count + 1);
                    @(posedge video_clock);
                    video_request = 1'b0;
                end
                video_done = 1'b1;
            end
            begin
                while (!video_done && wr_count < 200) begin
                    host_txn(1'b1, 13'h1000 + 13'(wr_count), 16'h3000 + 16'(wr_count * 7), 1, 2);
                    wr_count++;
                end
            end
        join
        @(posedge video_clock);
        host_txn(1'b0, 13'h1000, 16'h0000, 3, 3);
        @(posedge video_clock);
        host_txn(1'b0, 13'h1000 + 13'(wr_count - 1), 16'h0000, 3, 3);

        repeat (10) @(posedge video_clock);
        check("video_data_hold", 32'(video_data), 32'(shadow_rd(13'h084F)));
        check("video_queue_empty", 32'(vq.size()), 32'h0);
        check("host_queue_empty", 32'(hq.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
